barrelshift: RTL and testbench

BARRELSHIFT -- requirements
Module: barrelshift

---
 rtl/barrelshift_if.sv | 24 ++
 rtl/barrelshift.sv | 68 ++++++
 tb/tb_barrelshift.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/barrelshift_if.sv
// Operand/result bundle for the barrel shifter: sampled operand fields plus the
// registered result. The master drives operands; the slave returns the result.
interface barrelshift_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
);
  logic [WIDTH-1:0] In;
  logic [SHW-1:0]   n;
  logic             Lr;
  logic [1:0]       mode;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output In, n, Lr, mode, in_valid,
    input  out, out_valid
  );

  modport slave (
    input  In, n, Lr, mode, in_valid,
    output out, out_valid
  );
endinterface

// File: rtl/barrelshift.sv
// Single-cycle registered barrel shifter: logical, arithmetic and rotate shifts
// in either direction, built as a log-depth chain of power-of-two mux stages.
module barrelshift #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst_n,
  barrelshift_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_LOGIC = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic             rotate;
  logic             sign_fill;
  logic [SHW:0][WIDTH-1:0] stage;
  logic [WIDTH-1:0] out_q;
  logic             valid_q;

  // Reserved mode falls through to logical; arithmetic left equals logical left,
  // so sign fill only applies to right shifts of a negative operand.
  always_comb begin
    mode_sel  = mode_e'(bus.mode);
    rotate    = (mode_sel == MODE_ROT);
    sign_fill = (mode_sel == MODE_ARITH) && !bus.Lr && bus.In[WIDTH-1];
  end

  assign stage[0] = bus.In;

  // Stage k shifts by 2**k when n[k] is set; vacated bits take either the
  // wrapped-out bits (rotate), the sign bit, or zero.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int S = 2 ** k;
    if (S < WIDTH) begin : g_shift
      logic [WIDTH-1:0] l_res;
      logic [WIDTH-1:0] r_res;
      always_comb begin
        l_res = {stage[k][WIDTH-1-S:0],
                 rotate ? stage[k][WIDTH-1:WIDTH-S] : {S{1'b0}}};
        r_res = {rotate ? stage[k][S-1:0] : {S{sign_fill}},
                 stage[k][WIDTH-1:S]};
      end
      assign stage[k+1] = !bus.n[k] ? stage[k] : (bus.Lr ? l_res : r_res);
    end else begin : g_pass
      assign stage[k+1] = stage[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) out_q <= stage[SHW];
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_barrelshift.sv
// Directed bench for barrelshift: driver pushes expected results with their issue
// cycle; a negedge monitor pops and checks value and one-cycle latency.
module tb_barrelshift;
  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrelshift_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();
  barrelshift #(.WIDTH(WIDTH), .SHW(SHW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [7:0] in;
    logic [2:0] n;
    logic       lr;
    logic [1:0] mode;
    logic [7:0] exp;
    string      name;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cycle = 0;
  logic [7:0]  last_exp;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got valid out=%0h want no output", bus.out);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 32'(bus.out), 32'(mon_e.data));
        check("out_latency", cycle, mon_e.cyc + 1);
      end
    end
  end

  task automatic send(input vec_t v);
    @(negedge clk);
    bus.In       = v.in;
    bus.n        = v.n;
    bus.Lr       = v.lr;
    bus.mode     = v.mode;
    bus.in_valid = 1'b1;
    sb.push_back('{data: v.exp, cyc: cycle});
    last_exp = v.exp;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vecs = '{
      '{8'h00, 3'd0, 1'b0, 2'b00, 8'h00, "zero"},
      '{8'h80, 3'd4, 1'b0, 2'b00, 8'h08, "lsr4"},
      '{8'h80, 3'd2, 1'b0, 2'b00, 8'h20, "lsr2"},
      '{8'h80, 3'd1, 1'b0, 2'b00, 8'h40, "lsr1"},
      '{8'hFF, 3'd7, 1'b0, 2'b00, 8'h01, "lsr7"},
      '{8'hFF, 3'd7, 1'b1, 2'b00, 8'h80, "lsl7"},
      '{8'h01, 3'd3, 1'b1, 2'b00, 8'h08, "lsl3"},
      '{8'h80, 3'd2, 1'b0, 2'b01, 8'hE0, "asr2"},
      '{8'h81, 3'd1, 1'b1, 2'b10, 8'h03, "rol1"},
      '{8'h81, 3'd1, 1'b0, 2'b10, 8'hC0, "ror1"},
      '{8'h80, 3'd3, 1'b0, 2'b11, 8'h10, "rsvd_r"},
      '{8'h40, 3'd3, 1'b0, 2'b01, 8'h08, "asr_pos"},
      '{8'h81, 3'd1, 1'b1, 2'b01, 8'h02, "asl"},
      '{8'h01, 3'd7, 1'b0, 2'b10, 8'h02, "ror7"},
      '{8'hA5, 3'd4, 1'b1, 2'b10, 8'h5A, "rol4"},
      '{8'hB7, 3'd0, 1'b1, 2'b10, 8'hB7, "rot_n0"},
      '{8'hC3, 3'd0, 1'b0, 2'b01, 8'hC3, "asr_n0"},
      '{8'h3C, 3'd2, 1'b1, 2'b00, 8'hF0, "lsl2"},
      '{8'h0F, 3'd4, 1'b1, 2'b11, 8'hF0, "rsvd_l"},
      '{8'hF0, 3'd7, 1'b0, 2'b01, 8'hFF, "asr7"},
      '{8'h96, 3'd3, 1'b0, 2'b10, 8'hD2, "ror3"},
      '{8'h81, 3'd7, 1'b1, 2'b10, 8'hC0, "rol7"}
    };

    rst_n        = 1'b0;
    bus.In       = '0;
    bus.n        = '0;
    bus.Lr       = 1'b0;
    bus.mode     = 2'b00;
    bus.in_valid = 1'b0;

    #2;
    check("reset_out_noclk", 32'(bus.out), 32'h0);
    check("reset_valid_noclk", 32'(bus.out_valid), 32'h0);
    repeat (2) @(negedge clk);
    check("reset_out", 32'(bus.out), 32'h0);
    check("reset_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;
    idle();
    idle();
    check("idle_valid", 32'(bus.out_valid), 32'h0);

    // Every vector back-to-back: covers the directed cases and the 8+ stream.
    foreach (vecs[i]) send(vecs[i]);
    idle();
    @(negedge clk);
    check("drop_valid", 32'(bus.out_valid), 32'h0);
    check("drop_hold", 32'(bus.out), 32'(last_exp));
    @(negedge clk);
    check("drop_hold2", 32'(bus.out), 32'(last_exp));

    send('{8'h55, 3'd1, 1'b1, 2'b00, 8'hAA, "pre_rst"});
    send('{8'h55, 3'd1, 1'b0, 2'b00, 8'h2A, "discard"});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(bus.out), 32'h0);
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    sb.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(bus.out_valid), 32'h0);
    check("post_rst_out", 32'(bus.out), 32'h0);

    send('{8'h33, 3'd2, 1'b1, 2'b10, 8'hCC, "first_after_rst"});
    idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1);
  end
endmodule
